// File: rtl/micro_hash_pkg.sv
// Shared widths, FSM state encoding and job record for the micro-hash scheduler.
// Types only: no logic, no latency, no flow control.
package micro_hash_pkg;
   localparam int PAYLOAD_W = 96;
   localparam int TARGET_W  = 8;
   localparam int NONCE_W   = 32;
   localparam int HASH_W    = 24;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_GAP  = 3'd4
   } state_t;

   typedef struct packed {
      logic [PAYLOAD_W-1:0] payload;
      logic [TARGET_W-1:0]  target;
   } job_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts one past the last winner and wraps.
// Purely combinational (0 cycles); it never stalls, and no grant is issued when req is empty.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] last,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id
);
   localparam int IDW = $clog2(NREQ);

   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      idx    = '0;
      found  = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IDW'((int'(last) + i) % NREQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end
endmodule

// File: rtl/micro_hash_sched.sv
// Shares one micro-hash core among NREQ job sources; ack one cycle after the IDLE grant, result one cycle after terminado/expiry.
// Requests are level-held until ack and simply wait while a job is in flight (LOAD/RUN/DONE/GAP).
module micro_hash_sched
   import micro_hash_pkg::*;
#(
   parameter int          NREQ       = 4,
   parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*PAYLOAD_W-1:0] req_payload,
   input  logic [NREQ*TARGET_W-1:0]  req_target,
   output logic [NREQ-1:0]           ack,
   output logic                      busy,
   output logic                      res_valid,
   output logic [$clog2(NREQ)-1:0]   res_id,
   output logic [NONCE_W-1:0]        res_nonce,
   output logic [HASH_W-1:0]         res_hash,
   output logic                      res_timeout,
   output logic [PAYLOAD_W-1:0]      core_payload,
   output logic [TARGET_W-1:0]       core_target,
   output logic                      core_active,
   input  logic                      core_terminado,
   input  logic [NONCE_W-1:0]        core_nonce,
   input  logic [HASH_W-1:0]         core_hash
);
   localparam int IDW = $clog2(NREQ);

   state_t          state;
   logic [IDW-1:0]  last;
   logic [IDW-1:0]  gnt_id;
   logic [NREQ-1:0] gnt;
   logic [31:0]     cnt;
   logic            expire;
   job_t            sel_job;
   job_t            job_q;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (req),
      .last   (last),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   always_comb begin
      sel_job = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_job.payload = req_payload[i*PAYLOAD_W +: PAYLOAD_W];
            sel_job.target  = req_target[i*TARGET_W +: TARGET_W];
         end
      end
   end

   assign expire       = (MAX_CYCLES != 32'd0) && (cnt == MAX_CYCLES - 32'd1);
   assign core_payload = job_q.payload;
   assign core_target  = job_q.target;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         last        <= IDW'(NREQ - 1);
         cnt         <= '0;
         job_q       <= '0;
         ack         <= '0;
         busy        <= 1'b0;
         res_valid   <= 1'b0;
         res_id      <= '0;
         res_nonce   <= '0;
         res_hash    <= '0;
         res_timeout <= 1'b0;
         core_active <= 1'b0;
      end else begin
         ack       <= '0;
         res_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  ack         <= gnt;
                  job_q       <= sel_job;
                  res_id      <= gnt_id;
                  busy        <= 1'b1;
                  core_active <= 1'b1;
                  state       <= ST_LOAD;
               end
            end
            // terminado may still be high from the previous job, so it is not looked at here
            ST_LOAD: begin
               cnt   <= '0;
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (core_terminado || expire) begin
                  res_nonce   <= core_nonce;
                  res_hash    <= core_hash;
                  res_timeout <= !core_terminado;
                  res_valid   <= 1'b1;
                  core_active <= 1'b0;
                  state       <= ST_DONE;
               end else if (cnt != '1) begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_DONE: begin
               last  <= res_id;
               busy  <= 1'b0;
               state <= ST_GAP;
            end
            ST_GAP:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_micro_hash_sched.sv
// Bench for micro_hash_sched: two instances (default watchdog, watchdog=16), each driving a behavioural core model
// whose terminado fires a programmable number of RUN cycles after LOAD.
module tb_micro_hash_sched;
   import micro_hash_pkg::*;

   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   logic [NREQ*96-1:0] req_payload;
   logic [NREQ*8-1:0]  req_target;
   logic [95:0]        pl [NREQ];
   logic [7:0]         tg [NREQ];

   logic [NREQ-1:0] req_m, req_w, ack_m, ack_w;
   logic            busy_m, busy_w, rv_m, rv_w, rt_m, rt_w;
   logic [1:0]      rid_m, rid_w;
   logic [31:0]     rn_m, rn_w;
   logic [23:0]     rh_m, rh_w;
   logic [95:0]     cp_m, cp_w;
   logic [7:0]      ct_m, ct_w;

   // core models: index 0 serves the main instance, index 1 the watchdog instance
   logic [1:0]  act, term;
   logic [31:0] cnonce [2];
   logic [23:0] chash [2];
   int          act_cnt [2];
   int          term_delay [2];
   bit          stale [2];
   logic [31:0] nonce_val [2];
   logic [23:0] hash_val [2];

   always @(posedge clk)
      for (int m = 0; m < 2; m++) act_cnt[m] <= act[m] ? act_cnt[m] + 1 : 0;

   always_comb begin
      term = '0;
      for (int m = 0; m < 2; m++) begin
         cnonce[m] = 32'h0;
         chash[m]  = 24'h0;
         term[m]   = stale[m] | (term_delay[m] != 0 && act[m] && act_cnt[m] == term_delay[m]);
         cnonce[m] = term[m] ? nonce_val[m] : (32'hA500_0000 | 32'(act_cnt[m]));
         chash[m]  = term[m] ? hash_val[m] : (24'h5A_0000 | 24'(act_cnt[m][15:0]));
      end
   end

   micro_hash_sched #(.NREQ(NREQ)) dut (
      .clk(clk), .reset(reset), .req(req_m), .req_payload(req_payload), .req_target(req_target),
      .ack(ack_m), .busy(busy_m), .res_valid(rv_m), .res_id(rid_m), .res_nonce(rn_m), .res_hash(rh_m),
      .res_timeout(rt_m), .core_payload(cp_m), .core_target(ct_m), .core_active(act[0]),
      .core_terminado(term[0]), .core_nonce(cnonce[0]), .core_hash(chash[0])
   );

   micro_hash_sched #(.NREQ(NREQ), .MAX_CYCLES(32'd16)) dut_wd (
      .clk(clk), .reset(reset), .req(req_w), .req_payload(req_payload), .req_target(req_target),
      .ack(ack_w), .busy(busy_w), .res_valid(rv_w), .res_id(rid_w), .res_nonce(rn_w), .res_hash(rh_w),
      .res_timeout(rt_w), .core_payload(cp_w), .core_target(ct_w), .core_active(act[1]),
      .core_terminado(term[1]), .core_nonce(cnonce[1]), .core_hash(chash[1])
   );

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_ack(input bit w, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if ((w ? ack_w : ack_m) != '0) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no ack within %0d cycles", w ? "wd_ack_wait" : "ack_wait", budget);
      end
   endtask

   task automatic wait_res(input bit w, input int budget, output int at);
      at = -1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (w ? rv_w : rv_m) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         tests++;
         fails++;
         $display("FAIL %s: no res_valid within %0d cycles", w ? "wd_res_wait" : "res_wait", budget);
      end
   endtask

   task automatic run_job(input string tag, input logic [3:0] pat, input int delay, input logic [31:0] nv,
                          input logic [23:0] hv, input int exp_id, input bit drop,
                          output int ack_at, output int res_at);
      logic [3:0] oh;
      oh            = 4'b0001 << exp_id;
      term_delay[0] = delay;
      nonce_val[0]  = nv;
      hash_val[0]   = hv;
      req_m         = pat;
      wait_ack(1'b0, 40, ack_at);
      if (ack_at >= 0) begin
         chk({tag, "_ack"}, ack_m, oh);
         chk({tag, "_onehot"}, $onehot(ack_m), 1);
         chk({tag, "_payload"}, cp_m, pl[exp_id]);
         chk({tag, "_target"}, ct_m, tg[exp_id]);
         chk({tag, "_busy"}, busy_m, 1);
         if (drop) req_m[exp_id] = 1'b0;
      end
      wait_res(1'b0, delay + 40, res_at);
      if (res_at >= 0) begin
         chk({tag, "_id"}, rid_m, exp_id);
         chk({tag, "_nonce"}, rn_m, nv);
         chk({tag, "_hash"}, rh_m, hv);
         chk({tag, "_tout"}, rt_m, 0);
         if (ack_at >= 0) chk({tag, "_lat"}, res_at - ack_at, delay + 1);
      end
   endtask

   typedef struct {
      logic [3:0]  pat;
      int          delay;
      logic [31:0] nonce;
      logic [23:0] hash;
      int          id;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #200000;
      $display("FAIL tb_timeout: simulation did not finish, %0d tests run", tests);
      $fatal(1, "bench time limit");
   end

   initial begin
      int a, r, raised, prev;

      tbl[0]  = '{4'b1111, 1, 32'h0000_a001, 24'h11_0001, 1};
      tbl[1]  = '{4'b1111, 2, 32'h0000_a002, 24'h11_0002, 2};
      tbl[2]  = '{4'b1111, 7, 32'h0000_a003, 24'h11_0003, 3};
      tbl[3]  = '{4'b1111, 3, 32'h0000_a004, 24'h11_0004, 0};
      tbl[4]  = '{4'b1111, 1, 32'h0000_a005, 24'h11_0005, 1};
      tbl[5]  = '{4'b1010, 4, 32'h0000_a006, 24'h11_0006, 3};
      tbl[6]  = '{4'b1010, 2, 32'h0000_a007, 24'h11_0007, 1};
      tbl[7]  = '{4'b0100, 5, 32'h0000_a008, 24'h11_0008, 2};
      tbl[8]  = '{4'b1001, 1, 32'h0000_a009, 24'h11_0009, 3};
      tbl[9]  = '{4'b0011, 6, 32'h0000_a00a, 24'h11_000a, 0};
      tbl[10] = '{4'b1000, 2, 32'h0000_a00b, 24'h11_000b, 3};
      tbl[11] = '{4'b0110, 3, 32'h0000_a00c, 24'h11_000c, 1};

      pl[0] = 96'h397d9f2f40ca9e6c6b1f3324;
      pl[1] = 96'h111122223333444455556666;
      pl[2] = 96'hdeadbeef0123456789abcdef;
      pl[3] = 96'h0f0f0f0ff0f0f0f0a5a5a5a5;
      tg[0] = 8'h0a;
      tg[1] = 8'hb1;
      tg[2] = 8'hc2;
      tg[3] = 8'hd3;
      for (int i = 0; i < NREQ; i++) begin
         req_payload[i*96 +: 96] = pl[i];
         req_target[i*8 +: 8]    = tg[i];
      end

      reset = 1'b1;
      req_m = '0;
      req_w = '0;
      for (int m = 0; m < 2; m++) begin
         stale[m]      = 1'b0;
         term_delay[m] = 0;
         nonce_val[m]  = '0;
         hash_val[m]   = '0;
      end
      repeat (3) @(negedge clk);
      chk("rst_ctl", {ack_m, busy_m, rv_m, rt_m, act[0]}, 0);
      chk("rst_res", {rid_m, rn_m, rh_m}, 0);
      chk("rst_core", {cp_m, ct_m}, 0);
      chk("rst_wd_ctl", {ack_w, busy_w, rv_w, rt_w, act[1]}, 0);
      reset = 1'b0;
      @(negedge clk);

      // single job, requester 0 gets first pick after reset
      raised = cyc;
      run_job("single", 4'b0001, 20, 32'h0000_0013, 24'h00_beef, 0, 1'b1, a, r);
      if (a >= 0) chk("single_ack_lat", a - raised, 1);
      chk("single_act_done", act[0], 0);
      @(negedge clk);
      chk("single_gap", {rv_m, act[0], busy_m}, 0);

      prev = -1;
      for (int i = 0; i < 12; i++) begin
         run_job($sformatf("rr%0d", i), tbl[i].pat, tbl[i].delay, tbl[i].nonce, tbl[i].hash,
                 tbl[i].id, 1'b0, a, r);
         if (i > 0 && a >= 0 && prev >= 0) chk($sformatf("rr%0d_gap", i), a - prev, 3);
         prev = r;
      end
      req_m = '0;
      repeat (3) @(negedge clk);

      // stale terminado held through IDLE and LOAD must not end the job
      stale[0]      = 1'b1;
      term_delay[0] = 5;
      nonce_val[0]  = 32'h0000_5a1e;
      hash_val[0]   = 24'h5a_1e00;
      req_m         = 4'b0100;
      wait_ack(1'b0, 20, a);
      req_m = '0;
      if (a >= 0) chk("stale_ack", ack_m, 4'b0100);
      @(negedge clk);
      stale[0] = 1'b0;
      wait_res(1'b0, 40, r);
      if (a >= 0 && r >= 0) chk("stale_lat", r - a, 6);
      if (r >= 0) chk("stale_nonce", rn_m, 32'h0000_5a1e);
      repeat (3) @(negedge clk);

      // reset in the middle of RUN with requester 2 pending
      term_delay[0] = 0;
      req_m         = 4'b0001;
      wait_ack(1'b0, 20, a);
      req_m = 4'b0100;
      repeat (5) @(negedge clk);
      chk("mid_run_active", {busy_m, act[0]}, 2'b11);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_rv0", rv_m, 0);
      @(negedge clk);
      chk("rst_mid_ctl", {ack_m, busy_m, rv_m, act[0]}, 0);
      term_delay[0] = 2;
      nonce_val[0]  = 32'h0000_0a0a;
      hash_val[0]   = 24'h00_0a0a;
      reset         = 1'b0;
      req_m         = 4'b0101;
      wait_ack(1'b0, 20, a);
      req_m[0] = 1'b0;
      if (a >= 0) chk("post_rst_ack", ack_m, 4'b0001);
      wait_res(1'b0, 40, r);
      if (r >= 0) chk("post_rst_id", rid_m, 0);
      run_job("post_rst2", 4'b0100, 3, 32'h0000_0b0b, 24'h00_0b0b, 2, 1'b1, a, r);
      req_m = '0;

      // watchdog: core never finishes
      term_delay[1] = 0;
      req_w         = 4'b0001;
      wait_ack(1'b1, 20, a);
      req_w = '0;
      wait_res(1'b1, 60, r);
      if (a >= 0 && r >= 0) chk("wd_lat", r - a, 17);
      if (r >= 0) begin
         chk("wd_tout", rt_w, 1);
         chk("wd_nonce", rn_w, 32'hA500_0010);
         chk("wd_hash", rh_w, 24'h5A_0010);
         chk("wd_id", rid_w, 0);
      end

      // following job completes normally
      term_delay[1] = 3;
      nonce_val[1]  = 32'h0000_0777;
      hash_val[1]   = 24'h00_0777;
      req_w         = 4'b0010;
      wait_ack(1'b1, 20, a);
      req_w = '0;
      if (a >= 0) chk("wd_next_ack", ack_w, 4'b0010);
      wait_res(1'b1, 40, r);
      if (a >= 0 && r >= 0) chk("wd_next_lat", r - a, 4);
      if (r >= 0) chk("wd_next_res", {rt_w, rn_w}, {1'b0, 32'h0000_0777});

      // terminado on the expiry cycle takes priority
      term_delay[1] = 16;
      nonce_val[1]  = 32'hfeed_0016;
      hash_val[1]   = 24'h16_cafe;
      req_w         = 4'b0100;
      wait_ack(1'b1, 20, a);
      req_w = '0;
      if (a >= 0) chk("sim_ack", ack_w, 4'b0100);
      wait_res(1'b1, 60, r);
      if (a >= 0 && r >= 0) chk("sim_lat", r - a, 17);
      if (r >= 0) begin
         chk("sim_tout", rt_w, 0);
         chk("sim_nonce", rn_w, 32'hfeed_0016);
         chk("sim_hash", rh_w, 24'h16_cafe);
      end
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/micro_hash_sched.md
# micro_hash_sched

Job scheduler that shares one `sistema_area` micro-hash nonce-search core between `NREQ` requesters. It accepts (payload, target) jobs, arbitrates round-robin, and drives `active` into the core. It waits for `terminado` or a watchdog timeout, then returns nonce/hash on a shared result bus tagged with the requester id. It sits between the host-side job sources and the single core instance.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `MAX_CYCLES`, 32'd1_000_000: watchdog budget in RUN cycles; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NREQ  per-requester job request; level, held until `ack`.
- `req_payload`  in  NREQ*96  flattened payloads, slot i = bits [96i+95:96i]; stable while `req[i]`.
- `req_target`  in  NREQ*8  flattened targets, slot i = [8i+7:8i].
- `ack`  out  NREQ  one-hot, one-cycle pulse: job i latched.
- `busy`  out  1  high from grant until result issued.
- `res_valid`  out  1  one-cycle pulse: result fields valid.
- `res_id`  out  clog2(NREQ)  requester that owns the result.
- `res_nonce`  out  32  nonce from core.
- `res_hash`  out  24  hash from core.
- `res_timeout`  out  1  1 = watchdog expired, fields are the last core values.
- `core_payload`  out  96  to core `payload`.
- `core_target`  out  8  to core `target`.
- `core_active`  out  1  to core `active`.
- `core_terminado`  in  1  from core.
- `core_nonce`  in  32  from core `nonceOut`.
- `core_hash`  in  24  from core `hashOut`.

## Operation
- States: IDLE, LOAD, RUN, DONE, GAP.
- IDLE: if any `req` is set, the arbiter picks the winner. Search starts at `last+1` and wraps modulo NREQ. Then: pulse `ack[w]`, latch payload/target into `core_payload`/`core_target`, store `res_id`, go to LOAD.
- LOAD: `core_active`=1, cycle counter cleared. `core_terminado` is ignored, because it may be stale from the previous job. Go to RUN.
- RUN: `core_active`=1, counter +1 per cycle.
  - `core_terminado`=1: capture `core_nonce`/`core_hash`, set `res_timeout`=0, go to DONE.
  - Counter == MAX_CYCLES-1 (MAX_CYCLES≠0) without terminado: capture the current core values, set `res_timeout`=1, go to DONE.
  - Terminado and expiry in the same cycle: terminado wins, `res_timeout`=0.
- DONE: `res_valid`=1 for exactly one cycle, `core_active`=0, `last`←`res_id`. Go to GAP.
- GAP: `core_active` stays 0 for one more cycle, which guarantees a low→high restart edge for the core. `busy` falls. Go to IDLE.
- Arbitration and fairness:
  - A requester deasserting `req` before `ack` is legal and simply not granted.
  - `req` arriving during non-IDLE states waits.
  - `req[i]` still high after its `ack` is a new job.
  - Round-robin guarantees each of N continuously requesting sources is served within N jobs.
- `core_payload`/`core_target` hold their value from the grant until the next grant.
- Counter is 32 bits, unsigned, and never wraps: it saturates at expiry.

## Timing
- Reset (any state, including mid-RUN):
  - Outputs: `ack`, `busy`, `res_valid`, `res_timeout`, `core_active` = 0; `res_id`, `res_nonce`, `res_hash`, `core_payload`, `core_target` = 0.
  - State and pointer: state = IDLE; `last` = NREQ-1, so requester 0 has top priority.
  - An in-flight job is dropped with no `res_valid`.
- All outputs are registered.
- `req` seen in IDLE at edge T gives `ack` and `core_active` high from T+1 (LOAD).
- `core_terminado` first sampled at the end of the RUN entry cycle T+2.
- `core_terminado` sampled at edge E gives `res_valid` during E+1.
- After `res_valid`, next grant no earlier than E+3 (GAP, then IDLE arbitration).
- Minimum job-to-job `core_active` low time: 2 cycles.

## Structure
- Package `micro_hash_pkg`:
  - widths `PAYLOAD_W`=96, `TARGET_W`=8, `NONCE_W`=32, `HASH_W`=24;
  - state encoding constants for IDLE/LOAD/RUN/DONE/GAP.
- Sub-module `rr_arbiter`, parameter NREQ, combinational:
  - inputs: `req`, `last`;
  - outputs: one-hot `gnt`, encoded `gnt_id`.
- Scheduler top holds the FSM, watchdog counter and result registers.
- Bench uses a behavioural core model with programmable terminado delay.

## Test plan
- Single job: `req[0]`, payload 96'h397d9f2f40ca9e6c6b1f3324, target 8'h0a, core finishes after 20 RUN cycles with nonce 32'h0000_0013 → `ack[0]` at T+1; one `res_valid` with `res_id`=0, nonce 32'h13, `res_timeout`=0; `core_active` low ≥2 cycles after.
- Round-robin: `req`=4'b1111 held continuously → grants in order 0,1,2,3,0; `ack` always one-hot.
- Timeout: MAX_CYCLES=16, core never asserts terminado → `res_valid` with `res_timeout`=1 exactly 16 RUN cycles after LOAD; next job proceeds normally.
- Simultaneous: terminado asserted on the expiry cycle (MAX_CYCLES=16) → `res_timeout`=0, nonce/hash from the core.
- Stale terminado: core holds `terminado`=1 from the previous job during LOAD → ignored; result issued only on a terminado seen in RUN.
- Reset mid-RUN with `req[2]` pending → no `res_valid`; after reset, with `req[2]` and `req[0]` both set, requester 0 is granted first.
